// File: rtl/mem_pkg.sv
// Shared encodings for the memory access unit: RV32I funct3 sizes, FSM states, access checks.
package mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Stores only have B/H/W; loads add the unsigned byte/half forms.
  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    if (is_store) return f3 inside {F3_B, F3_H, F3_W};
    return f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU};
  endfunction

  function automatic logic misaligned(input logic [1:0] lo, input logic [2:0] f3);
    case (f3[1:0])
      2'b01:   return lo[0];
      2'b10:   return lo != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane selection for loads (sign/zero extension) and lane merge for sub-word stores.
// Purely combinational; no state, no flow control.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  output logic [31:0] load_val,
  output logic [31:0] store_word
);

  logic [7:0]  b;
  logic [15:0] h;

  always_comb begin
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    h = lane[1] ? word[31:16] : word[15:0];

    case (funct3)
      F3_B:    load_val = {{24{b[7]}}, b};
      F3_H:    load_val = {{16{h[15]}}, h};
      F3_BU:   load_val = {24'd0, b};
      F3_HU:   load_val = {16'd0, h};
      default: load_val = word;
    endcase

    store_word = word;
    case (funct3)
      F3_B: begin
        case (lane)
          2'd0:    store_word[7:0]   = wdata[7:0];
          2'd1:    store_word[15:8]  = wdata[7:0];
          2'd2:    store_word[23:16] = wdata[7:0];
          default: store_word[31:24] = wdata[7:0];
        endcase
      end
      F3_H: begin
        if (lane[1]) store_word[31:16] = wdata[15:0];
        else         store_word[15:0]  = wdata[15:0];
      end
      default: store_word = wdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// Converts core load/store strobes into aligned word accesses with extension and RMW lane merge.
// Latency strobe->ready: fault 1, SW 2, load 3, SB/SH 4; strobes outside IDLE are ignored.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int IDX_W     = $clog2(MEM_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mem_RE,
  input  logic             mem_WE,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  input  logic [2:0]       funct3,
  output logic [31:0]      rdata,
  output logic             ready,
  output logic             fault,
  output logic             busy,
  output logic [IDX_W-1:0] ram_idx,
  output logic             ram_re,
  output logic             ram_we,
  output logic [31:0]      ram_wdata,
  input  logic [31:0]      ram_rdata
);

  localparam logic [31:0] MEM_WORDS_L = 32'(MEM_WORDS);

  state_t      state;
  logic [1:0]  lane_q;
  logic [2:0]  f3_q;
  logic [31:0] wdata_q;
  logic        store_q;
  logic        re_q;
  logic        we_q;
  logic        req;
  logic        fault_c;
  logic [31:0] load_val;
  logic [31:0] store_word;

  always_comb begin
    req     = mem_RE | mem_WE;
    fault_c = (mem_RE & mem_WE)
            | misaligned(addr[1:0], funct3)
            | ~f3_legal(mem_WE, funct3)
            | ({2'b00, addr[31:2]} >= MEM_WORDS_L);
  end

  mem_lane_align u_align (
    .lane       (lane_q),
    .funct3     (f3_q),
    .word       (ram_rdata),
    .wdata      (wdata_q),
    .load_val   (load_val),
    .store_word (store_word)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      lane_q    <= 2'd0;
      f3_q      <= 3'd0;
      wdata_q   <= 32'd0;
      store_q   <= 1'b0;
      re_q      <= 1'b0;
      we_q      <= 1'b0;
      rdata     <= 32'd0;
      ready     <= 1'b0;
      fault     <= 1'b0;
      ram_idx   <= '0;
      ram_wdata <= 32'd0;
    end else begin
      ready <= 1'b0;
      fault <= 1'b0;
      re_q  <= 1'b0;
      we_q  <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req) begin
            lane_q  <= addr[1:0];
            f3_q    <= funct3;
            wdata_q <= wdata;
            store_q <= mem_WE;
            if (fault_c) begin
              state <= ST_DONE;
              ready <= 1'b1;
              fault <= 1'b1;
            end else if (mem_WE && funct3 == F3_W) begin
              state     <= ST_WRITE;
              we_q      <= 1'b1;
              ram_idx   <= addr[IDX_W+1:2];
              ram_wdata <= wdata;
            end else begin
              state   <= ST_READ;
              re_q    <= 1'b1;
              ram_idx <= addr[IDX_W+1:2];
            end
          end
        end
        ST_READ: state <= ST_WAIT;
        ST_WAIT: begin
          if (store_q) begin
            ram_wdata <= store_word;
            we_q      <= 1'b1;
            state     <= ST_WRITE;
          end else begin
            rdata <= load_val;
            ready <= 1'b1;
            state <= ST_DONE;
          end
        end
        ST_WRITE: begin
          ready <= 1'b1;
          state <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Reset blocks the array strobes in the same cycle it is asserted.
  assign ram_re = re_q & ~rst;
  assign ram_we = we_q & ~rst;
  assign busy   = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and random load/store sequences checked against a byte-addressed memory model.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 1024;
  localparam int IDX_W     = 10;

  logic             clk = 1'b0;
  logic             rst;
  logic             mem_RE, mem_WE;
  logic [31:0]      addr, wdata;
  logic [2:0]       funct3;
  logic [31:0]      rdata;
  logic             ready, fault, busy;
  logic [IDX_W-1:0] ram_idx;
  logic             ram_re, ram_we;
  logic [31:0]      ram_wdata;
  logic [31:0]      ram_rdata;

  logic [31:0] ram  [MEM_WORDS];
  logic [7:0]  refm [4*MEM_WORDS];

  int total = 0;
  int bad = 0;
  int re_cnt = 0, we_cnt = 0, rdy_cnt = 0, overlap = 0;
  logic [IDX_W-1:0] last_widx;
  logic [31:0]      last_wdat;
  logic [31:0]      exp_rdata;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS)) dut (
    .clk(clk), .rst(rst), .mem_RE(mem_RE), .mem_WE(mem_WE), .addr(addr),
    .wdata(wdata), .funct3(funct3), .rdata(rdata), .ready(ready), .fault(fault),
    .busy(busy), .ram_idx(ram_idx), .ram_re(ram_re), .ram_we(ram_we),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= ram_wdata;
    if (ram_re) ram_rdata <= ram[ram_idx];
  end

  always @(negedge clk) begin
    if (ram_re) re_cnt++;
    if (ram_we) begin
      we_cnt++;
      last_widx = ram_idx;
      last_wdat = ram_wdata;
    end
    if (ready) rdy_cnt++;
    if (ram_re && ram_we) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_word(input int i, input logic [31:0] w);
    ram[i] = w;
    for (int k = 0; k < 4; k++) refm[4*i+k] = w[8*k +: 8];
  endtask

  function automatic int acc_size(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic bit ref_fault(input logic re, input logic we, input logic [31:0] a,
                                   input logic [2:0] f3);
    bit bad_f3;
    bad_f3 = we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 >= 3'd6);
    return (re && we) || bad_f3 || (a % acc_size(f3) != 0) || (a / 4 >= MEM_WORDS);
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [2:0] f3);
    int n;
    logic [31:0] v;
    n = acc_size(f3);
    v = 32'd0;
    for (int k = 0; k < n; k++) v = v | (32'(refm[a+k]) << (8*k));
    if (!f3[2] && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
    return v;
  endfunction

  function automatic logic [31:0] ref_word(input int i);
    return {refm[4*i+3], refm[4*i+2], refm[4*i+1], refm[4*i]};
  endfunction

  task automatic do_op(input logic re, input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3, input string tag);
    int re0, we0, n, lat;
    bit flt, seen;
    logic [31:0] exp_val;
    flt = ref_fault(re, we, a, f3);
    lat = flt ? 1 : (we ? ((f3 == 3'b010) ? 2 : 4) : 3);
    exp_val = flt ? 32'd0 : ref_load(a, f3);
    re0 = re_cnt;
    we0 = we_cnt;
    @(negedge clk);
    mem_RE = re; mem_WE = we; addr = a; wdata = wd; funct3 = f3;
    n = 0;
    seen = 0;
    while (!seen && n < 20) begin
      @(posedge clk); #1;
      n++;
      if (ready) seen = 1;
    end
    mem_RE = 1'b0;
    mem_WE = 1'b0;
    if (!flt && re) exp_rdata = exp_val;
    check({tag, " latency"}, 32'(n), 32'(lat));
    check({tag, " fault"}, 32'(fault), 32'(flt));
    check({tag, " rdata"}, rdata, exp_rdata);
    @(posedge clk); #1;
    check({tag, " ready pulse"}, 32'(ready), 32'd0);
    check({tag, " idle"}, 32'(busy), 32'd0);
    check({tag, " ram_re count"}, 32'(re_cnt - re0), (flt || (we && f3 == 3'b010)) ? 32'd0 : 32'd1);
    check({tag, " ram_we count"}, 32'(we_cnt - we0), (!flt && we) ? 32'd1 : 32'd0);
    if (!flt && we) begin
      for (int k = 0; k < acc_size(f3); k++) refm[a+k] = wd[8*k +: 8];
      check({tag, " write idx"}, 32'(last_widx), a >> 2);
      check({tag, " write word"}, last_wdat, ref_word(int'(a >> 2)));
    end
  endtask

  initial begin
    int r0, q0;
    logic [31:0] a, wd;
    logic [2:0]  f3;
    logic        re, we;

    rst = 1'b1; mem_RE = 1'b0; mem_WE = 1'b0;
    addr = 32'd0; wdata = 32'd0; funct3 = 3'd0;
    for (int i = 0; i < MEM_WORDS; i++) set_word(i, $urandom);
    set_word(64, 32'hDEADBEEF);
    exp_rdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset rdata", rdata, 32'd0);
    check("reset ctl", {27'd0, ready, fault, busy, ram_re, ram_we}, 32'd0);
    check("reset idx", 32'(ram_idx), 32'd0);
    check("reset wdata", ram_wdata, 32'd0);

    do_op(1, 0, 32'h100, 32'h0, 3'b010, "LW 0x100");
    check("LW value", rdata, 32'hDEADBEEF);
    do_op(0, 1, 32'h100, 32'h80FF7F01, 3'b010, "SW 0x100");
    do_op(1, 0, 32'h103, 32'h0, 3'b000, "LB 0x103");
    check("LB value", rdata, 32'hFFFFFF80);
    do_op(1, 0, 32'h103, 32'h0, 3'b100, "LBU 0x103");
    check("LBU value", rdata, 32'h00000080);
    do_op(1, 0, 32'h102, 32'h0, 3'b001, "LH 0x102");
    check("LH value", rdata, 32'hFFFF80FF);
    set_word(64, 32'h11223344);
    do_op(0, 1, 32'h101, 32'h000000AA, 3'b000, "SB 0x101");
    check("SB merged", last_wdat, 32'h1122AA44);
    do_op(0, 1, 32'h104, 32'h12345678, 3'b010, "SW 0x104");
    check("SW idx", 32'(last_widx), 32'd65);
    do_op(1, 0, 32'h104, 32'h0, 3'b010, "LW 0x104");
    check("LW after SW", rdata, 32'h12345678);
    do_op(0, 1, 32'h106, 32'hCAFEBABE, 3'b001, "SH 0x106");
    do_op(1, 0, 32'h106, 32'h0, 3'b101, "LHU 0x106");
    check("LHU value", rdata, 32'h0000BABE);

    do_op(1, 0, 32'h102, 32'h0, 3'b010, "LW misaligned");
    do_op(1, 0, 32'h001, 32'h0, 3'b001, "LH misaligned");
    do_op(0, 1, 32'(4*MEM_WORDS), 32'h55, 3'b010, "SW out of range");
    do_op(1, 0, 32'h100, 32'h0, 3'b011, "load f3 011");
    do_op(0, 1, 32'h100, 32'h0, 3'b100, "store f3 100");
    do_op(1, 1, 32'h100, 32'h0, 3'b010, "RE and WE");

    // Abort an SH from its WAIT cycle.
    q0 = we_cnt;
    @(negedge clk);
    mem_WE = 1'b1; addr = 32'h108; wdata = 32'hFFFF; funct3 = 3'b001;
    @(posedge clk); #1;
    mem_WE = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_rdata = 32'd0;
    check("rst abort busy", 32'(busy), 32'd0);
    check("rst abort ready", 32'(ready), 32'd0);
    check("rst abort wdata", ram_wdata, 32'd0);
    repeat (6) @(posedge clk);
    #1;
    check("rst abort no write", 32'(we_cnt - q0), 32'd0);
    check("rst abort mem intact", ram[66], ref_word(66));

    // Strobe held across 12 edges: one acceptance per IDLE visit, every 4 cycles.
    r0 = rdy_cnt;
    q0 = re_cnt;
    @(negedge clk);
    mem_RE = 1'b1; addr = 32'h104; funct3 = 3'b010;
    repeat (12) @(posedge clk);
    #1;
    mem_RE = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp_rdata = ref_load(32'h104, 3'b010);
    check("held strobe readys", 32'(rdy_cnt - r0), 32'd3);
    check("held strobe reads", 32'(re_cnt - q0), 32'd3);
    check("held strobe rdata", rdata, exp_rdata);

    for (int t = 0; t < 40; t++) begin
      f3 = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      re = !we || ($urandom_range(0, 9) == 0);
      a = 32'($urandom_range(0, 63)) + 32'h200;
      if ($urandom_range(0, 7) == 0) a = 32'(4*MEM_WORDS) + 32'($urandom_range(0, 255));
      wd = $urandom;
      do_op(re, we, a, wd, f3, "random op");
    end

    check("re/we overlap", 32'(overlap), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
